// File: rtl/sr_latch_driver_pkg.sv
// Shared types for the RS-latch write controller: FSM state codes, latch
// operation kinds and the retry limit used when SR_LATCH_DRIVER_RETRY_EN is set.
package sr_latch_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_DRIVE  = 2'd1;
   localparam state_t ST_SETTLE = 2'd2;
   localparam state_t ST_CHECK  = 2'd3;

   typedef enum logic [1:0] {
      OP_SET = 2'd0,
      OP_RST = 2'd1,
      OP_CLR = 2'd2
   } op_e;

   localparam int MAX_RETRY = 2;

endpackage

// File: rtl/sr_latch_driver_if.sv
// Core-side write port plus latch-side drive/readback for sr_latch_driver.
// Handshake: a write transfers on a rising edge where wr_valid & wr_ready are both
// high; wr_ready drops while clr_req is high because a clear wins that cycle.
interface sr_latch_driver_if;
   import sr_latch_pkg::*;

   logic   wr_valid;
   logic   wr_data;
   logic   wr_ready;
   logic   clr_req;
   logic   busy;
   logic   done;
   logic   err;
   logic   s;
   logic   r;
   logic   clr;
   logic   q;
   logic   qn;
   state_t dbg_state;

   modport master (
      output wr_valid, wr_data, clr_req, q, qn,
      input  wr_ready, busy, done, err, s, r, clr, dbg_state
   );

   modport slave (
      input  wr_valid, wr_data, clr_req, q, qn,
      output wr_ready, busy, done, err, s, r, clr, dbg_state
   );
endinterface

// File: rtl/sr_latch_driver_pulse_counter.sv
// Loadable down-counter with zero flag, timing both the drive pulse and the
// settle wait. Load has priority over decrement.
module sr_pulse_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic             i_dec,
   input  logic [CNT_W-1:0] i_load_val,
   output logic [CNT_W-1:0] o_count,
   output logic             o_zero
);
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);
endmodule

// File: rtl/sr_latch_driver.sv
// Write-side controller for an external RS latch with clear: pulses s/r/clr,
// waits to settle, then checks q/qn. Retries are added by SR_LATCH_DRIVER_RETRY_EN.
module sr_latch_driver
   import sr_latch_pkg::*;
#(
   parameter int PULSE_W  = 2,
   parameter int SETTLE_W = 1,
   parameter int CNT_W    = 4
) (
   input logic              clk,
   input logic              rst,
   sr_latch_driver_if.slave bus
);
   localparam int PULSE_LD_I  = (PULSE_W > 0) ? PULSE_W - 1 : 0;
   localparam int SETTLE_LD_I = (SETTLE_W > 0) ? SETTLE_W - 1 : 0;
   localparam logic [CNT_W-1:0] PULSE_LD  = PULSE_LD_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] SETTLE_LD = SETTLE_LD_I[CNT_W-1:0];

   if (PULSE_W < 1) begin : g_bad_pulse_w
      $error("sr_latch_driver: PULSE_W must be at least 1");
   end

   state_t           r_state;
   op_e              r_op;
   logic             r_exp;
   logic             r_s;
   logic             r_r;
   logic             r_clr;
   logic             r_err;
   logic             w_accept_clr;
   logic             w_accept_wr;
   logic             w_fail;
   logic             w_retry;
   logic             w_load;
   logic             w_dec;
   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_count;
   logic             w_zero;

   assign w_accept_clr = (r_state == ST_IDLE) && bus.clr_req;
   assign w_accept_wr  = (r_state == ST_IDLE) && !bus.clr_req && bus.wr_valid;
   assign w_fail       = (bus.q == bus.qn) || (bus.q != r_exp);

`ifdef SR_LATCH_DRIVER_RETRY_EN
   logic [1:0] r_retry;

   assign w_retry = (r_state == ST_CHECK) && w_fail && (r_op != OP_CLR) &&
                    (r_retry < 2'(MAX_RETRY));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_retry <= 2'd0;
      end else if (w_accept_clr || w_accept_wr) begin
         r_retry <= 2'd0;
      end else if (w_retry) begin
         r_retry <= r_retry + 2'd1;
      end
   end
`else
   assign w_retry = 1'b0;
`endif

   // A retry reloads the pulse length exactly like a fresh accept.
   always_comb begin
      w_load     = 1'b0;
      w_dec      = 1'b0;
      w_load_val = PULSE_LD;
      if (w_accept_clr || w_accept_wr || w_retry) begin
         w_load = 1'b1;
      end else if (r_state == ST_DRIVE && w_zero && SETTLE_W != 0) begin
         w_load     = 1'b1;
         w_load_val = SETTLE_LD;
      end else if ((r_state == ST_DRIVE || r_state == ST_SETTLE) && !w_zero) begin
         w_dec = 1'b1;
      end
   end

   sr_pulse_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_dec      (w_dec),
      .i_load_val (w_load_val),
      .o_count    (w_count),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_op    <= OP_SET;
         r_exp   <= 1'b0;
         r_s     <= 1'b0;
         r_r     <= 1'b0;
         r_clr   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept_clr) begin
                  r_state <= ST_DRIVE;
                  r_op    <= OP_CLR;
                  r_exp   <= 1'b0;
                  r_clr   <= 1'b1;
                  r_err   <= 1'b0;
               end else if (w_accept_wr) begin
                  r_state <= ST_DRIVE;
                  r_op    <= bus.wr_data ? OP_SET : OP_RST;
                  r_exp   <= bus.wr_data;
                  r_s     <= bus.wr_data;
                  r_r     <= !bus.wr_data;
               end
            end
            ST_DRIVE: begin
               if (w_zero) begin
                  r_s     <= 1'b0;
                  r_r     <= 1'b0;
                  r_clr   <= 1'b0;
                  r_state <= (SETTLE_W == 0) ? ST_CHECK : ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (w_zero) r_state <= ST_CHECK;
            end
            default: begin
               if (w_retry) begin
                  r_state <= ST_DRIVE;
                  r_s     <= (r_op == OP_SET);
                  r_r     <= (r_op == OP_RST);
               end else begin
                  r_state <= ST_IDLE;
                  if (w_fail) r_err <= 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.wr_ready  = (r_state == ST_IDLE) && !bus.clr_req;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.done      = (r_state == ST_CHECK) && !w_retry;
   assign bus.err       = r_err;
   assign bus.s         = r_s;
   assign bus.r         = r_r;
   assign bus.clr       = r_clr;
   assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: behavioural latch, operation-level reference model
// feeding an expected queue, and a monitor that checks every done pulse.
module tb_sr_latch_driver;
   localparam int PULSE_W  = 2;
   localparam int SETTLE_W = 1;
   localparam int CNT_W    = 4;
`ifdef SR_LATCH_DRIVER_RETRY_EN
   localparam int ATT_ON_FAIL = 3;
`else
   localparam int ATT_ON_FAIL = 1;
`endif
   localparam int OP_LEN = PULSE_W + SETTLE_W + 1;
   localparam int K_SET  = 0;
   localparam int K_RST  = 1;
   localparam int K_CLR  = 2;
   localparam int W      = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   sr_latch_driver_if bus ();

   sr_latch_driver #(
      .PULSE_W  (PULSE_W),
      .SETTLE_W (SETTLE_W),
      .CNT_W    (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural latch; fault forces q = qn = 0.
   logic latch_q = 1'b0;
   bit   fault   = 1'b0;
   always @(posedge clk) begin
      if (bus.clr)    latch_q <= 1'b0;
      else if (bus.s) latch_q <= 1'b1;
      else if (bus.r) latch_q <= 1'b0;
   end
   assign bus.q  = fault ? 1'b0 : latch_q;
   assign bus.qn = fault ? 1'b0 : ~latch_q;

   logic [W-1:0] exp_q[$];
   bit           err_m = 1'b0;
   int           last_done_cyc = -10;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Operation-level model: each op is PULSE_W drive + SETTLE_W wait + 1 check
   // cycle per attempt; a bad readback fails and makes err sticky until a clear.
   task automatic push_op(input int kind, input int acc_cyc);
      bit fail;
      int att;
      fail = fault;
      att  = (fail && kind != K_CLR) ? ATT_ON_FAIL : 1;
      if (kind == K_CLR) err_m = fail;
      else               err_m = err_m | fail;
      exp_q.push_back({2'(kind), 2'(att), err_m, 15'(acc_cyc + att * OP_LEN)});
   endtask

   int s_cnt = 0, r_cnt = 0, c_cnt = 0, inv_bad = 0;
   bit err_pend = 1'b0, exp_err = 1'b0;

   always @(negedge clk) begin
      logic [W-1:0] item;
      int kind, att;
      if (rst) begin
         s_cnt = 0; r_cnt = 0; c_cnt = 0; err_pend = 1'b0;
      end else begin
         if ((bus.s & bus.r) | (bus.s & bus.clr) | (bus.r & bus.clr)) inv_bad++;
         if (err_pend) begin
            check("err_after_check", int'(bus.err), int'(exp_err));
            err_pend = 1'b0;
         end
         s_cnt += int'(bus.s);
         r_cnt += int'(bus.r);
         c_cnt += int'(bus.clr);
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_done");
            end else begin
               item = exp_q.pop_front();
               kind = int'(item[19:18]);
               att  = int'(item[17:16]);
               check("done_cycle", cyc % 32768, int'(item[14:0]));
               check("s_pulse_cycles", s_cnt, (kind == K_SET) ? att * PULSE_W : 0);
               check("r_pulse_cycles", r_cnt, (kind == K_RST) ? att * PULSE_W : 0);
               check("clr_pulse_cycles", c_cnt, (kind == K_CLR) ? PULSE_W : 0);
               exp_err  = item[15];
               err_pend = 1'b1;
               last_done_cyc = cyc;
            end
            s_cnt = 0; r_cnt = 0; c_cnt = 0;
         end
      end
   end

   task automatic issue_wr(input bit data);
      int waited = 0;
      bus.wr_valid = 1'b1;
      bus.wr_data  = data;
      while (!bus.wr_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.wr_ready) begin
         fail_now("wr_accept_timeout");
      end else begin
         check("done_to_accept_gap", int'(cyc > last_done_cyc), 1);
         push_op(data ? K_SET : K_RST, cyc);
      end
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic issue_clr();
      int waited = 0;
      bus.clr_req = 1'b1;
      while (bus.busy && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (bus.busy) fail_now("clr_accept_timeout");
      else          push_op(K_CLR, cyc);
      @(negedge clk);
      bus.clr_req = 1'b0;
   endtask

   task automatic wait_idle();
      int waited = 0;
      while ((exp_q.size() != 0 || bus.busy) && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (exp_q.size() != 0 || bus.busy) fail_now("idle_timeout");
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_expired (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int waited;
      bus.wr_valid = 1'b0;
      bus.wr_data  = 1'b0;
      bus.clr_req  = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_s", int'(bus.s), 0);
      check("reset_r", int'(bus.r), 0);
      check("reset_clr", int'(bus.clr), 0);
      check("reset_wr_ready", int'(bus.wr_ready), 1);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_done", int'(bus.done), 0);
      check("reset_err", int'(bus.err), 0);
      rst = 1'b0;
      @(negedge clk);

      issue_wr(1'b1);
      wait_idle();
      issue_wr(1'b0);
      wait_idle();

      // Clear and write raised together: clear goes first, write follows done.
      bus.clr_req  = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 1'b1;
      acc = cyc;
      push_op(K_CLR, acc);
      @(negedge clk);
      bus.clr_req = 1'b0;
      check("wr_ready_low_during_clr", int'(bus.wr_ready), 0);
      waited = 0;
      while (!bus.wr_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("wr_accept_after_clr_done", cyc, acc + OP_LEN + 1);
      push_op(K_SET, cyc);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      wait_idle();

      fault = 1'b1;
      issue_wr(1'b1);
      wait_idle();
      fault = 1'b0;
      issue_wr(1'b0);
      wait_idle();
      check("err_sticky_after_good_write", int'(bus.err), 1);
      issue_clr();
      wait_idle();
      check("err_cleared_by_clr", int'(bus.err), 0);

      // Reset during the first drive cycle.
      issue_wr(1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_s", int'(bus.s), 0);
      check("rst_mid_busy", int'(bus.busy), 0);
      check("rst_mid_wr_ready", int'(bus.wr_ready), 1);
      check("rst_mid_done", int'(bus.done), 0);
      exp_q.delete();
      err_m = 1'b0;
      rst = 1'b0;
      repeat (8) @(negedge clk);

      for (int i = 0; i < 1500; i++) begin
         if (i % 60 == 0) begin
            wait_idle();
            fault = ($urandom_range(0, 5) == 0);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 7) == 0) issue_clr();
         else                           issue_wr(1'($urandom_range(0, 1)));
      end
      wait_idle();
      fault = 1'b0;

      check("s_r_clr_exclusive_violations", inv_bad, 0);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
